// File: rtl/hw_nios_debug_pkg.sv
// Shared constants and types for the Nios debug memory controller:
// FSM encoding, JTAG command-word field positions and RAM geometry.
package hw_nios_debug_pkg;

    localparam int DATA_W            = 32;
    localparam int ADDR_W            = 8;
    localparam int BE_W              = DATA_W / 8;
    localparam int RAM_WORDS_DEFAULT = 256;

    localparam int JDO_W         = 38;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_ADDR_MSB  = 25;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_CRD  = 2'd2
    } state_e;

    // Word addresses wrap naturally at the top of the 8-bit space.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/hw_nios_debug_ram.sv
// Single-port debug RAM with per-byte write enables and a registered read port.
// Contents are never reset; q only updates on an enabled access.
module hw_nios_debug_ram
    import hw_nios_debug_pkg::*;
#(
    parameter int WORDS = RAM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] q_lane;

            // Read-before-write: a write cycle returns the old lane contents.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && be[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    q_lane <= mem[addr];
                end
            end

            assign q[gi*8 +: 8] = q_lane;
        end
    endgenerate

endmodule

// File: rtl/hw_nios_debug_mem_ctrl.sv
// Arbitrates the debug RAM between JTAG monitor commands and the CPU slave port.
// Pending JTAG commands win in IDLE; a started CPU read always finishes.
module hw_nios_debug_mem_ctrl
    import hw_nios_debug_pkg::*;
#(
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy
);

    state_e              state_q, state_d;
    logic                rd_pend_q, rd_pend_d;
    logic                wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]   wbuf_q, wbuf_d;
    logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
    logic [DATA_W-1:0]   mon_d_q, mon_d_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic                ram_en, ram_we;
    logic [BE_W-1:0]     ram_be;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_q;
    logic                cpu_done;

    logic                unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        wr_pend_d = wr_pend_q;
        wbuf_d    = wbuf_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        rdata_d   = rdata_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = mon_a_q;
        ram_wdata = wbuf_q;
        cpu_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_pend_q) begin
                    ram_en    = 1'b1;
                    rd_pend_d = 1'b0;
                    state_d   = ST_JRD;
                end else if (wr_pend_q) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    wr_pend_d = 1'b0;
                    mon_a_d   = addr_inc(mon_a_q);
                end else if (avs_write) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_be    = avs_byteenable;
                    ram_addr  = avs_address;
                    ram_wdata = avs_writedata;
                    cpu_done  = 1'b1;
                end else if (avs_read) begin
                    ram_en    = 1'b1;
                    ram_addr  = avs_address;
                    state_d   = ST_CRD;
                end
            end
            ST_JRD: begin
                mon_d_d = ram_q;
                state_d = ST_IDLE;
            end
            ST_CRD: begin
                rdata_d  = ram_q;
                cpu_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh command overrides whatever is still pending; ocimem_a beats ocimem_b.
        if (take_action_ocimem_a) begin
            mon_a_d   = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
            rd_pend_d = jdo[JDO_RD_BIT];
            wr_pend_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
            mon_a_d   = addr_inc(mon_a_q);
            rd_pend_d = 1'b1;
            wr_pend_d = 1'b0;
        end else if (take_action_ocimem_b) begin
            wbuf_d    = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            wr_pend_d = 1'b1;
            rd_pend_d = 1'b0;
        end

        busy_d = rd_pend_d | wr_pend_d | (state_d == ST_JRD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wbuf_q    <= '0;
            mon_a_q   <= '0;
            mon_d_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            wbuf_q    <= wbuf_d;
            mon_a_q   <= mon_a_d;
            mon_d_q   <= mon_d_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
        end
    end

    // Gating with reset_n guarantees an access interrupted by reset never lands in RAM.
    hw_nios_debug_ram #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en & reset_n),
        .we    (ram_we & reset_n),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    assign avs_readdata    = (state_q == ST_CRD) ? ram_q : rdata_q;
    assign avs_waitrequest = ~reset_n | ((avs_read | avs_write) & ~cpu_done);
    assign MonDReg         = mon_d_q;
    assign MonAReg         = mon_a_q;
    assign jtag_busy       = busy_q;

endmodule

// File: tb/tb_hw_nios_debug_mem_ctrl.sv
// Directed self-checking bench for hw_nios_debug_mem_ctrl: JTAG and CPU access
// paths, arbitration, address wrap and reset behaviour.
module tb_hw_nios_debug_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;

    int checks = 0;
    int errors = 0;

    hw_nios_debug_mem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input bit rd, input logic [7:0] a);
        jdo = '0;
        jdo[35] = rd;
        jdo[25:18] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_next();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic wait_seen);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        #1;
        wait_seen = avs_waitrequest;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    // Holds avs_read until waitrequest drops (bounded), returns data and cycle count.
    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int cycles);
        int n = 0;
        avs_address = a; avs_read = 1'b1;
        #1;
        while (avs_waitrequest && n < 20) begin
            tick();
            n++;
        end
        d = avs_readdata;
        cycles = n + 1;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        avs_read = 1'b1;
        tick(); tick();
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b want 1", avs_waitrequest); end
        checks++; if (MonAReg !== 8'h00) begin errors++; $display("FAIL reset_mona: got %h want 00", MonAReg); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mond: got %h want 0", MonDReg); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", avs_readdata); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", jtag_busy); end
        avs_read = 1'b0;
        reset_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_jtag_write();
        pulse_a(1'b0, 8'h10);
        checks++; if (MonAReg !== 8'h10) begin errors++; $display("FAIL jwr_addr: got %h want 10", MonAReg); end
        pulse_b(32'hDEADBEEF);
        checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jwr_busy: got %b want 1", jtag_busy); end
        tick();
        checks++; if (MonAReg !== 8'h11) begin errors++; $display("FAIL jwr_inc: got %h want 11", MonAReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jwr_idle: got %b want 0", jtag_busy); end
        $display("test_jtag_write done");
    endtask

    task automatic test_jtag_read();
        pulse_a(1'b1, 8'h10);
        checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jrd_busy1: got %b want 1", jtag_busy); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL jrd_early1: got %h want 0", MonDReg); end
        tick();
        checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jrd_busy2: got %b want 1", jtag_busy); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL jrd_early2: got %h want 0", MonDReg); end
        tick();
        checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL jrd_data: got %h want deadbeef", MonDReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jrd_done: got %b want 0", jtag_busy); end
        checks++; if (MonAReg !== 8'h10) begin errors++; $display("FAIL jrd_addr: got %h want 10", MonAReg); end
        $display("test_jtag_read done");
    endtask

    task automatic test_read_next_wrap();
        pulse_a(1'b0, 8'h00);
        pulse_b(32'hA5A50001);
        tick();
        pulse_a(1'b0, 8'hFF);
        checks++; if (MonAReg !== 8'hFF) begin errors++; $display("FAIL wrap_load: got %h want ff", MonAReg); end
        pulse_next();
        checks++; if (MonAReg !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h want 00", MonAReg); end
        tick(); tick();
        checks++; if (MonDReg !== 32'hA5A50001) begin errors++; $display("FAIL wrap_data: got %h want a5a50001", MonDReg); end
        $display("test_read_next_wrap done");
    endtask

    task automatic test_cpu_write_read();
        logic        w;
        logic [31:0] d;
        int          c;
        pulse_a(1'b0, 8'h20);
        pulse_b(32'hCAFEBABE);
        tick();
        cpu_write(8'h20, 32'h12345678, 4'b0011, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL cwr_wait: got %b want 0", w); end
        cpu_read(8'h20, d, c);
        checks++; if (d !== 32'hCAFE5678) begin errors++; $display("FAIL crd_data: got %h want cafe5678", d); end
        checks++; if (c != 2) begin errors++; $display("FAIL crd_cycles: got %0d want 2", c); end
        avs_read = 1'b1;
        cpu_write(8'h30, 32'h0BADF00D, 4'hF, w);
        avs_read = 1'b0;
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL rw_wait: got %b want 0", w); end
        cpu_read(8'h30, d, c);
        checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL rw_data: got %h want 0badf00d", d); end
        $display("test_cpu_write_read done");
    endtask

    task automatic test_jtag_priority();
        logic [31:0] d;
        int          c;
        pulse_a(1'b1, 8'h10);
        cpu_read(8'h20, d, c);
        checks++; if (c != 4) begin errors++; $display("FAIL prio_cycles: got %0d want 4", c); end
        checks++; if (d !== 32'hCAFE5678) begin errors++; $display("FAIL prio_cdata: got %h want cafe5678", d); end
        checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_jdata: got %h want deadbeef", MonDReg); end
        $display("test_jtag_priority done");
    endtask

    task automatic test_back_to_back();
        logic        w1, w2;
        logic [31:0] d;
        int          c;
        cpu_write(8'h40, 32'h11111111, 4'hF, w1);
        cpu_write(8'h41, 32'h22222222, 4'hF, w2);
        checks++; if (w1 !== 1'b0 || w2 !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b%b want 00", w1, w2); end
        cpu_read(8'h40, d, c);
        checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL b2b_rd0: got %h want 11111111", d); end
        cpu_read(8'h41, d, c);
        checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL b2b_rd1: got %h want 22222222", d); end
        checks++; if (c != 2) begin errors++; $display("FAIL b2b_cycles: got %0d want 2", c); end
        $display("test_back_to_back done");
    endtask

    task automatic test_cmd_collision();
        jdo = '0;
        jdo[25:18] = 8'h50;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        checks++; if (MonAReg !== 8'h50) begin errors++; $display("FAIL coll_addr: got %h want 50", MonAReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b want 0", jtag_busy); end
        tick();
        checks++; if (MonAReg !== 8'h50) begin errors++; $display("FAIL coll_nowr: got %h want 50", MonAReg); end
        $display("test_cmd_collision done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          c;
        pulse_a(1'b0, 8'h40);
        jdo = '0;
        jdo[34:3] = 32'hFFFFFFFF;
        take_action_ocimem_b = 1'b1;
        avs_address = 8'h41;
        avs_read = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_crd_wait: got %b want 1", avs_waitrequest); end
        tick();
        avs_read = 1'b0;
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_crd_rdata: got %h want 0", avs_readdata); end
        checks++; if (MonAReg !== 8'h00) begin errors++; $display("FAIL rst_crd_mona: got %h want 00", MonAReg); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_crd_mond: got %h want 0", MonDReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL rst_crd_busy: got %b want 0", jtag_busy); end
        reset_n = 1'b1;
        tick(); tick();
        cpu_read(8'h40, d, c);
        checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL rst_ram40: got %h want 11111111", d); end
        cpu_read(8'h41, d, c);
        checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL rst_ram41: got %h want 22222222", d); end
        pulse_b(32'hFFFFFFFF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cpu_read(8'h00, d, c);
        checks++; if (d !== 32'hA5A50001) begin errors++; $display("FAIL rst_ram00: got %h want a5a50001", d); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        #1;
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_read_next_wrap();
        test_cpu_write_read();
        test_jtag_priority();
        test_back_to_back();
        test_cmd_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_nios_debug_mem_ctrl.md
HW_NIOS_DEBUG_MEM_CTRL -- requirements
Module: hw_nios_debug_mem_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset_n, which is synchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- jdo  in  38  JTAG command/data word, sysclk domain
- take_action_ocimem_a  in  1  1-cycle pulse: address/read command
- take_action_ocimem_b  in  1  1-cycle pulse: write-data command
- take_no_action_ocimem_a  in  1  1-cycle pulse: read-next command
- avs_address  in  8  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte lanes
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  CPU stall
- MonDReg  out  32  JTAG read-data register
- MonAReg  out  8  JTAG word-address register
- jtag_busy  out  1  JTAG access pending or in flight
REQ-003 Parameter: RAM_WORDS, default 256, is the debug RAM depth in 32-bit words (8-bit address).

Function
REQ-004 jdo fields SHALL be: [35] read flag, [25:18] word address, [34:3] write data.
REQ-005 take_action_ocimem_a SHALL load MonAReg <= jdo[25:18]. If jdo[35]=1, it SHALL also set jtag_rd_pend.
REQ-006 take_no_action_ocimem_a SHALL increment MonAReg by 1, wrapping 255->0, and set jtag_rd_pend.
REQ-007 take_action_ocimem_b SHALL latch jdo[34:3] into the write buffer and set jtag_wr_pend. The write SHALL go to the current MonAReg; MonAReg SHALL increment (wrapping) when the write issues.
REQ-008 When ocimem_a and ocimem_b pulse in the same cycle, ocimem_a SHALL be honoured and ocimem_b dropped. A new command while one is pending SHALL replace the pending command.
REQ-009 The FSM SHALL have states IDLE, JRD, CRD.
- IDLE with a JTAG pend: issue the RAM access; a write completes in IDLE, a read goes to JRD.
- Else IDLE with avs_write: issue a byte-enabled write, waitrequest=0 that cycle.
- Else IDLE with avs_read: issue a read, go to CRD.
- JRD -> IDLE: capture RAM q into MonDReg.
- CRD -> IDLE: avs_readdata=q, waitrequest=0.
REQ-010 The RAM SHALL have 1-cycle registered read latency. A JTAG read SHALL update MonDReg at the third rising edge after the pulse cycle, if IDLE and unblocked. A CPU read SHALL complete in 2 cycles, a CPU write in 1.
REQ-011 avs_waitrequest SHALL be 1 whenever avs_read or avs_write is asserted and not being completed this cycle. It SHALL be 0 when neither is asserted.
REQ-012 JTAG pends SHALL have priority over CPU requests in IDLE; an in-flight CRD SHALL never be aborted.
REQ-013 jtag_busy SHALL be 1 from the cycle after a command pulse until the cycle after completion.
REQ-014 Simultaneous avs_read and avs_write SHALL be treated as a write.

Reset
REQ-015 While reset_n=0 at a clock edge, the block SHALL reset: FSM=IDLE, pends=0, MonAReg=0, MonDReg=0, avs_readdata=0, jtag_busy=0.
REQ-016 avs_waitrequest SHALL be 1 during reset.
REQ-017 RAM contents SHALL NOT be reset.
REQ-018 A reset mid-operation SHALL discard in-flight accesses with no RAM write issued.

Structure
REQ-019 Package hw_nios_debug_pkg SHALL hold the FSM state encoding, the jdo field bit positions, and the RAM_WORDS/address-width constants.
REQ-020 The RAM SHALL be one sub-module, hw_nios_debug_ram: single port, 256x32, byteenable, registered q.

Verification
REQ-021 ocimem_a with jdo[25:18]=0x10 and [35]=0, then ocimem_b with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF and MonAReg=0x11.
REQ-022 ocimem_a with address 0x10 and read flag=1 -> MonDReg=0xDEADBEEF three edges after the pulse; jtag_busy high for the 2 intermediate cycles.
REQ-023 MonAReg=0xFF, then take_no_action_ocimem_a -> MonAReg=0x00 and MonDReg=RAM[0x00].
REQ-024 CPU write 0x12345678 at address 0x20 with byteenable 0b0011, then read -> readdata=0x????5678 (upper bytes unchanged); write waitrequest=0 in 1 cycle, read in 2.
REQ-025 JTAG read pend and avs_read asserted in the same IDLE cycle -> JTAG is served first; CPU waitrequest=1 for 2 extra cycles, then correct data.
REQ-026 reset_n=0 during CRD -> outputs take their reset values next edge; no RAM corruption.
